apb_reg_slave: RTL
==================

# apb_reg_slave

APB4 completer (slave) holding a small register bank. It is the far end of the APB link driven by the team's AHB-to-APB bridge. It accepts setup/access transfers, inserts a fixed number of wait states, applies PSTRB byte-lane writes and flags PSLVERR on illegal accesses. It is the standard APB target for bridge bring-up and system-level tests.

## Interface
- ADDR_WIDTH, 32, PADDR width
- DATA_WIDTH, 32, PWDATA/PRDATA width; multiple of 8
- NUM_REGS, 16, number of 32-bit word slots, power of two, >= 4
- WAIT_CYCLES, 2, wait states per transfer (0..15)
- ID_VALUE, 32'hA5B0_0001, constant returned by the ID register
- PCLK  in  1  the single clock; all state changes on rising edge
- PRESET  in  1  reset, synchronous and active-high
- PSEL  in  1  completer select
- PENABLE  in  1  access-phase indicator
- PPROT  in  3  protection; captured but does not affect decode
- PWRITE  in  1  1 = write, 0 = read
- PSTRB  in  DATA_WIDTH/8  write byte strobes
- PADDR  in  ADDR_WIDTH  byte address
- PWDATA  in  DATA_WIDTH  write data
- PRDATA  out  DATA_WIDTH  read data, valid when PREADY=1 on a read
- PREADY  out  1  transfer-complete
- PSLVERR  out  1  error response, valid only with PREADY=1

## Operation
- Register map (word offset = PADDR/4):
  - Offsets 0..NUM_REGS-3: read/write, byte-strobed.
  - Offset NUM_REGS-2: ID, read-only, reads ID_VALUE.
  - Offset NUM_REGS-1: CNT, counts transfers completed with PSLVERR=0 (reads and writes), saturating at all-ones. Any write to CNT clears it to 0; that write is not counted.
- Error conditions, decoded from setup-phase signals. Any one of these gives PSLVERR=1 on the completing cycle:
  - PADDR[1:0] != 0
  - PADDR >= NUM_REGS*4
  - Write to ID
  - Read with PSTRB != 0
- An errored transfer has no side effects: no register write, no CNT change. PRDATA = 0.
- Writes commit on the completing cycle (PSEL & PENABLE & PREADY) only. Byte lane i is updated only if PSTRB[i]=1. A write with PSTRB=0 is legal and changes no data, but it does increment CNT.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS when PSEL=1 and PENABLE=0 (setup). In that cycle, latch address, PWRITE, PSTRB, error flag and read data; load the wait counter with WAIT_CYCLES.
  - In ACCESS with PSEL=1 and PENABLE=1: decrement the wait counter while it is non-zero.
  - ACCESS -> IDLE on the completing cycle.
  - ACCESS -> IDLE immediately if PSEL=0 (aborted transfer, no side effects).
  - Back-to-back transfers: a new setup cycle follows completion directly; IDLE accepts it in the very next cycle.
- PENABLE=1 seen in IDLE (no setup) is ignored and PREADY stays 0.

## Timing
- PREADY = (state==ACCESS) & (wait counter==0), decoded from registers only; no combinational path from inputs.
- With WAIT_CYCLES=N, PREADY rises in access cycle N+1. Total transfer is N+2 PCLK cycles including setup.
- PRDATA and PSLVERR are registered at the end of setup. They are driven only while PREADY=1 and are 0 otherwise.
- A read of CNT returns the value before the current transfer is counted.
- Reset (PRESET=1 at a rising edge):
  - FSM goes to IDLE, wait counter to 0, all RW registers and CNT to 0.
  - PREADY=0, PSLVERR=0, PRDATA=0 from the cycle after the edge.
  - Reset mid-transfer drops the transfer with no write.
- PRESET has priority over every other input.
- Simultaneous completion of a CNT-clearing write and a counted event cannot occur, since one transfer is in flight at a time.

## Test plan
- Reset, then write 0xDEADBEEF to 0x08 with PSTRB=0xF, WAIT_CYCLES=2 -> PREADY high in the 3rd access cycle, PSLVERR=0; a read of 0x08 returns 0xDEADBEEF and CNT reads 2.
- Write 0x11223344 to 0x04, then write 0xAABBCCDD with PSTRB=0b0101 -> a read of 0x04 returns 0x11BB33DD.
- Read 0x38 -> 0xA5B00001. Write to 0x38 -> PSLVERR=1 and the ID is unchanged. Read 0x40 -> PSLVERR=1, PRDATA=0. Write to 0x09 -> PSLVERR=1 and no register changes.
- Read with PSTRB=0x1 -> PSLVERR=1. Write any value to 0x3C -> CNT reads 0 afterwards.
- Assert PSEL, then drop it during the 1st access cycle of a write to 0x0C -> no PREADY, 0x0C keeps its old value; the next normal transfer completes correctly.
- Assert PRESET during the access phase of a write to 0x10 -> PREADY=0 next cycle; all registers and CNT read 0 after reset.

Source files
------------

// File: rtl/apb_reg_slave.sv
// APB4 completer with a small byte-strobed register bank, an ID word and a
// saturating count of successful transfers. Fixed wait-state insertion.
module apb_reg_slave #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [2:0]              PPROT,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int unsigned STRB_W  = DATA_WIDTH / 8;
  localparam int unsigned IDX_W   = $clog2(NUM_REGS);
  localparam int unsigned NUM_RW  = NUM_REGS - 2;
  localparam int unsigned ID_IDX  = NUM_REGS - 2;
  localparam int unsigned CNT_IDX = NUM_REGS - 1;
  localparam int unsigned WAIT_W  = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Transfer context captured in the setup cycle
  logic [WAIT_W-1:0]     wait_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;
  logic [STRB_W-1:0]     strb_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [2:0]            pprot_unused_q;

  // Register bank
  logic [DATA_WIDTH-1:0] regs_q [NUM_RW];
  logic [DATA_WIDTH-1:0] cnt_q;

  // Setup-phase decode
  logic                  setup_c;
  logic                  complete_c;
  logic [IDX_W-1:0]      idx_c;
  logic                  err_c;
  logic [DATA_WIDTH-1:0] rdata_c;
  logic                  cnt_inc_c;
  logic                  cnt_clr_c;

  // Decode the address and error conditions from the setup-phase inputs
  always_comb begin
    setup_c = (state_q == IDLE) && PSEL && !PENABLE;
    idx_c   = PADDR[IDX_W+1:2];
    err_c   = (PADDR[1:0] != 2'b00)
           || (PADDR >= ADDR_WIDTH'(NUM_REGS * 4))
           || (PWRITE && (idx_c == IDX_W'(ID_IDX)))
           || (!PWRITE && (PSTRB != '0));
    rdata_c = '0;
    if (!err_c && !PWRITE) begin
      if (idx_c < IDX_W'(NUM_RW)) begin
        rdata_c = regs_q[idx_c];
      end else if (idx_c == IDX_W'(ID_IDX)) begin
        rdata_c = DATA_WIDTH'(ID_VALUE);
      end else begin
        rdata_c = cnt_q;
      end
    end
  end

  // Completion and counter-update qualifiers
  always_comb begin
    complete_c = (state_q == ACCESS) && PSEL && PENABLE && (wait_q == '0);
    cnt_clr_c  = complete_c && !err_q && write_q && (idx_q == IDX_W'(CNT_IDX));
    cnt_inc_c  = complete_c && !err_q && !(write_q && (idx_q == IDX_W'(CNT_IDX)));
  end

  // FSM state register
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (setup_c) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!PSEL || complete_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture transfer context at setup and count down wait states
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wait_q         <= '0;
      idx_q          <= '0;
      write_q        <= 1'b0;
      strb_q         <= '0;
      err_q          <= 1'b0;
      rdata_q        <= '0;
      pprot_unused_q <= '0;
    end else if (setup_c) begin
      wait_q         <= WAIT_W'(WAIT_CYCLES);
      idx_q          <= idx_c;
      write_q        <= PWRITE;
      strb_q         <= PSTRB;
      err_q          <= err_c;
      rdata_q        <= rdata_c;
      pprot_unused_q <= PPROT;
    end else if ((state_q == ACCESS) && PSEL && PENABLE && (wait_q != '0)) begin
      wait_q <= wait_q - WAIT_W'(1);
    end
  end

  // Commit byte-strobed writes on the completing cycle
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int r = 0; r < NUM_RW; r++) begin
        regs_q[r] <= '0;
      end
    end else if (complete_c && !err_q && write_q && (idx_q < IDX_W'(NUM_RW))) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (strb_q[b]) begin
          regs_q[idx_q][b*8 +: 8] <= PWDATA[b*8 +: 8];
        end
      end
    end
  end

  // Saturating count of error-free transfers; a write to it clears it
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt_q <= '0;
    end else if (cnt_clr_c) begin
      cnt_q <= '0;
    end else if (cnt_inc_c && (cnt_q != '1)) begin
      cnt_q <= cnt_q + DATA_WIDTH'(1);
    end
  end

  // Response outputs come only from registered state
  assign PREADY  = (state_q == ACCESS) && (wait_q == '0);
  assign PRDATA  = PREADY ? rdata_q : '0;
  assign PSLVERR = PREADY ? err_q : 1'b0;

endmodule
